// File: rtl/pcie_tl_tx_arb_if.sv
// Requester, credit and TLP-stream bundle for the PCIe TL transmit arbiter.
// master = arbiter side, slave = requesters / DLL side.
interface pcie_tl_tx_arb_if #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int CREDIT_DEPTH    = 12,
  parameter int RETRY_DEPTH_LG2 = 8
);
  logic                       link_active_i;
  logic [RETRY_DEPTH_LG2-1:0] retry_leftover_i;
  logic                       p_req_i, np_req_i, cpl_req_i;
  logic [PIPE_DATA_WIDTH-1:0] p_hdr_i, np_hdr_i, cpl_hdr_i;
  logic [9:0]                 p_len_i, cpl_len_i;
  logic                       p_gnt_o, np_gnt_o, cpl_gnt_o;
  logic [PIPE_DATA_WIDTH-1:0] p_data_i, cpl_data_i;
  logic                       p_data_rd_o, cpl_data_rd_o;
  logic [CREDIT_DEPTH-1:0]    cl_ph_i, cl_pd_i, cl_nh_i, cl_ch_i, cl_cd_i;
  logic [CREDIT_DEPTH-1:0]    cc_ph_o, cc_pd_o, cc_nh_o, cc_ch_o, cc_cd_o;
  logic [PIPE_DATA_WIDTH-1:0] tlp_o;
  logic [2:0]                 req_o;

  modport master (
    input  link_active_i, retry_leftover_i,
    input  p_req_i, np_req_i, cpl_req_i, p_hdr_i, np_hdr_i, cpl_hdr_i,
    input  p_len_i, cpl_len_i, p_data_i, cpl_data_i,
    input  cl_ph_i, cl_pd_i, cl_nh_i, cl_ch_i, cl_cd_i,
    output p_gnt_o, np_gnt_o, cpl_gnt_o, p_data_rd_o, cpl_data_rd_o,
    output cc_ph_o, cc_pd_o, cc_nh_o, cc_ch_o, cc_cd_o, tlp_o, req_o
  );

  modport slave (
    output link_active_i, retry_leftover_i,
    output p_req_i, np_req_i, cpl_req_i, p_hdr_i, np_hdr_i, cpl_hdr_i,
    output p_len_i, cpl_len_i, p_data_i, cpl_data_i,
    output cl_ph_i, cl_pd_i, cl_nh_i, cl_ch_i, cl_cd_i,
    input  p_gnt_o, np_gnt_o, cpl_gnt_o, p_data_rd_o, cpl_data_rd_o,
    input  cc_ph_o, cc_pd_o, cc_nh_o, cc_ch_o, cc_cd_o, tlp_o, req_o
  );
endinterface

// File: rtl/pcie_tl_tx_arb.sv
// Transmit TLP scheduler: round-robin P/NP/CPL onto one TLP beat stream, gated by link,
// FC credits and retry space. Macro PCIE_TX_CPL_PRIO_EN: completions win over P/NP.
module pcie_tl_tx_arb #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int CREDIT_DEPTH    = 12,
  parameter int RETRY_DEPTH_LG2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  pcie_tl_tx_arb_if.master bus
);
  localparam int CD = CREDIT_DEPTH;
  localparam logic [2:0] REQ_IDLE     = 3'd0;
  localparam logic [2:0] REQ_P_HDR    = 3'd1;
  localparam logic [2:0] REQ_P_DATA   = 3'd2;
  localparam logic [2:0] REQ_NP_HDR   = 3'd3;
  localparam logic [2:0] REQ_CPL_HDR  = 3'd5;
  localparam logic [2:0] REQ_CPL_DATA = 3'd6;
  localparam logic [1:0] CLS_P   = 2'd0;
  localparam logic [1:0] CLS_NP  = 2'd1;
  localparam logic [1:0] CLS_CPL = 2'd2;

  typedef enum logic {ST_ARB, ST_DATA} state_t;

  state_t                     r_state;
  logic                       r_cls_cpl;
  logic [7:0]                 r_cnt;
  logic [1:0]                 r_ptr;
  logic [PIPE_DATA_WIDTH-1:0] r_tlp;
  logic [2:0]                 r_req;
  logic [CD-1:0]              r_cc_ph, r_cc_pd, r_cc_nh, r_cc_ch, r_cc_cd;

  function automatic logic [10:0] len_eff(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

  // Limit ahead of consumed-after-grant by less than half the counter range.
  function automatic logic credit_ok(input logic [CD-1:0] cl, input logic [CD-1:0] cc,
                                     input logic [CD-1:0] add);
    logic [CD-1:0] d;
    d = cl - (cc + add);
    return ~d[CD-1];
  endfunction

  logic [10:0]   w_p_len, w_cpl_len;
  logic [CD-1:0] w_p_dcr, w_cpl_dcr;
  logic [7:0]    w_p_beats, w_cpl_beats;
  logic [31:0]   w_retry;
  logic [2:0]    w_elig, w_gnt;
  logic [1:0]    w_ptr_nxt;

  assign w_p_len     = len_eff(bus.p_len_i);
  assign w_cpl_len   = len_eff(bus.cpl_len_i);
  assign w_p_dcr     = CD'((w_p_len + 11'd3) >> 2);
  assign w_cpl_dcr   = CD'((w_cpl_len + 11'd3) >> 2);
  assign w_p_beats   = 8'((w_p_len + 11'd7) >> 3);
  assign w_cpl_beats = 8'((w_cpl_len + 11'd7) >> 3);
  assign w_retry     = 32'(bus.retry_leftover_i);

  // retry >= beats + 1 is written as retry > beats
  assign w_elig[0] = bus.p_req_i & bus.link_active_i
                   & credit_ok(bus.cl_ph_i, r_cc_ph, CD'(1))
                   & credit_ok(bus.cl_pd_i, r_cc_pd, w_p_dcr)
                   & (w_retry > 32'(w_p_beats));
  assign w_elig[1] = bus.np_req_i & bus.link_active_i
                   & credit_ok(bus.cl_nh_i, r_cc_nh, CD'(1))
                   & (w_retry > 32'd0);
  assign w_elig[2] = bus.cpl_req_i & bus.link_active_i
                   & credit_ok(bus.cl_ch_i, r_cc_ch, CD'(1))
                   & credit_ok(bus.cl_cd_i, r_cc_cd, w_cpl_dcr)
                   & (w_retry > 32'(w_cpl_beats));

  always_comb begin
    w_gnt     = 3'b000;
    w_ptr_nxt = r_ptr;
    if (!rst && r_state == ST_ARB) begin
`ifdef PCIE_TX_CPL_PRIO_EN
      if (w_elig[2])            w_gnt = 3'b100;
      else if (r_ptr == CLS_NP) w_gnt = w_elig[1] ? 3'b010 : (w_elig[0] ? 3'b001 : 3'b000);
      else                      w_gnt = w_elig[0] ? 3'b001 : (w_elig[1] ? 3'b010 : 3'b000);
      if (w_gnt[0])      w_ptr_nxt = CLS_NP;
      else if (w_gnt[1]) w_ptr_nxt = CLS_P;
`else
      case (r_ptr)
        CLS_NP:  w_gnt = w_elig[1] ? 3'b010 : w_elig[2] ? 3'b100 : w_elig[0] ? 3'b001 : 3'b000;
        CLS_CPL: w_gnt = w_elig[2] ? 3'b100 : w_elig[0] ? 3'b001 : w_elig[1] ? 3'b010 : 3'b000;
        default: w_gnt = w_elig[0] ? 3'b001 : w_elig[1] ? 3'b010 : w_elig[2] ? 3'b100 : 3'b000;
      endcase
      if (w_gnt[0])      w_ptr_nxt = CLS_NP;
      else if (w_gnt[1]) w_ptr_nxt = CLS_CPL;
      else if (w_gnt[2]) w_ptr_nxt = CLS_P;
`endif
    end
  end

  assign bus.p_gnt_o       = w_gnt[0];
  assign bus.np_gnt_o      = w_gnt[1];
  assign bus.cpl_gnt_o     = w_gnt[2];
  assign bus.p_data_rd_o   = !rst && r_state == ST_DATA && !r_cls_cpl;
  assign bus.cpl_data_rd_o = !rst && r_state == ST_DATA &&  r_cls_cpl;
  assign bus.tlp_o         = r_tlp;
  assign bus.req_o         = r_req;
  assign bus.cc_ph_o       = r_cc_ph;
  assign bus.cc_pd_o       = r_cc_pd;
  assign bus.cc_nh_o       = r_cc_nh;
  assign bus.cc_ch_o       = r_cc_ch;
  assign bus.cc_cd_o       = r_cc_cd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ARB;
      r_cls_cpl <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= CLS_P;
      r_tlp     <= '0;
      r_req     <= REQ_IDLE;
      r_cc_ph   <= '0;
      r_cc_pd   <= '0;
      r_cc_nh   <= '0;
      r_cc_ch   <= '0;
      r_cc_cd   <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          r_ptr <= w_ptr_nxt;
          if (w_gnt[0]) begin
            r_tlp     <= bus.p_hdr_i;
            r_req     <= REQ_P_HDR;
            r_cc_ph   <= r_cc_ph + CD'(1);
            r_cc_pd   <= r_cc_pd + w_p_dcr;
            r_cnt     <= w_p_beats;
            r_cls_cpl <= 1'b0;
            r_state   <= ST_DATA;
          end else if (w_gnt[1]) begin
            r_tlp   <= bus.np_hdr_i;
            r_req   <= REQ_NP_HDR;
            r_cc_nh <= r_cc_nh + CD'(1);
          end else if (w_gnt[2]) begin
            r_tlp     <= bus.cpl_hdr_i;
            r_req     <= REQ_CPL_HDR;
            r_cc_ch   <= r_cc_ch + CD'(1);
            r_cc_cd   <= r_cc_cd + w_cpl_dcr;
            r_cnt     <= w_cpl_beats;
            r_cls_cpl <= 1'b1;
            r_state   <= ST_DATA;
          end else begin
            r_req <= REQ_IDLE;
          end
        end
        default: begin
          // packet always drains; link/limits are not looked at here
          r_tlp <= r_cls_cpl ? bus.cpl_data_i : bus.p_data_i;
          r_req <= r_cls_cpl ? REQ_CPL_DATA : REQ_P_DATA;
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= ST_ARB;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_tl_tx_arb.sv
// Directed bench for pcie_tl_tx_arb: reset, single packet, round-robin, credits, wrap, retry, link drop, priority.
module tb_pcie_tl_tx_arb;
  localparam int PW = 256;
  localparam int CD = 12;
  localparam int RL = 8;
  localparam logic [PW-1:0] P_HDR   = 256'h1111_0001;
  localparam logic [PW-1:0] NP_HDR  = 256'h2222_0002;
  localparam logic [PW-1:0] CPL_HDR = 256'h3333_0003;

  logic clk;
  logic rst;

  pcie_tl_tx_arb_if #(.PIPE_DATA_WIDTH(PW), .CREDIT_DEPTH(CD), .RETRY_DEPTH_LG2(RL)) bus ();
  pcie_tl_tx_arb #(.PIPE_DATA_WIDTH(PW), .CREDIT_DEPTH(CD), .RETRY_DEPTH_LG2(RL)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int p_pend, np_pend, cpl_pend, p_idx, cpl_idx, exp_pd;
  logic [2:0]    s_gnt, s_req;
  logic [1:0]    s_rd;
  logic [PW-1:0] s_tlp;
  logic [2:0]    tr_req[32];
  logic [2:0]    tr_gnt[32];
  logic [PW-1:0] tr_tlp[32];

  function automatic logic [PW-1:0] pdat(input int i);
    return PW'(32'hD000_0000 + 32'(i));
  endfunction
  function automatic logic [PW-1:0] cdat(input int i);
    return PW'(32'hC000_0000 + 32'(i));
  endfunction

  task automatic drive();
    bus.p_req_i    = (p_pend > 0);
    bus.np_req_i   = (np_pend > 0);
    bus.cpl_req_i  = (cpl_pend > 0);
    bus.p_data_i   = pdat(p_idx);
    bus.cpl_data_i = cdat(cpl_idx);
  endtask

  // Sample at negedge, then let the requester models react just after the posedge.
  task automatic step();
    @(negedge clk);
    s_gnt = {bus.cpl_gnt_o, bus.np_gnt_o, bus.p_gnt_o};
    s_rd  = {bus.cpl_data_rd_o, bus.p_data_rd_o};
    s_req = bus.req_o;
    s_tlp = bus.tlp_o;
    @(posedge clk);
    #1;
    if (s_gnt[0]) p_pend--;
    if (s_gnt[1]) np_pend--;
    if (s_gnt[2]) cpl_pend--;
    if (s_rd[0]) p_idx++;
    if (s_rd[1]) cpl_idx++;
    drive();
  endtask

  task automatic run_trace(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      tr_req[k] = s_req;
      tr_gnt[k] = s_gnt;
      tr_tlp[k] = s_tlp;
    end
  endtask

  task automatic set_lim(input int v);
    bus.cl_ph_i = CD'(v); bus.cl_pd_i = CD'(v); bus.cl_nh_i = CD'(v);
    bus.cl_ch_i = CD'(v); bus.cl_cd_i = CD'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p_pend = 0; np_pend = 0; cpl_pend = 0; p_idx = 0; cpl_idx = 0;
    bus.link_active_i = 1'b1;
    bus.retry_leftover_i = 8'd255;
    set_lim(100);
    drive();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p_pend = 1; np_pend = 1; cpl_pend = 1; p_idx = 0; cpl_idx = 0;
    bus.link_active_i = 1'b1; bus.retry_leftover_i = 8'd255; set_lim(100);
    bus.p_len_i = 10'd32;
    drive();
    step(); step();
    checks++; if (s_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", s_gnt); end
    checks++; if (s_rd !== 2'b00) begin errors++; $display("FAIL reset_rd: got %b expected 00", s_rd); end
    checks++; if (s_req !== 3'd0 || s_tlp !== '0) begin errors++; $display("FAIL reset_stream: got req %0d tlp %0h expected 0 0", s_req, s_tlp); end
    checks++; if ({bus.cc_ph_o, bus.cc_pd_o, bus.cc_nh_o, bus.cc_ch_o, bus.cc_cd_o} !== '0) begin
      errors++; $display("FAIL reset_cc: got %0h expected 0", {bus.cc_ph_o, bus.cc_pd_o, bus.cc_nh_o, bus.cc_ch_o, bus.cc_cd_o}); end
    // reset mid-packet
    np_pend = 0; cpl_pend = 0; rst = 1'b0; drive();
    step(); step();
    rst = 1'b1; p_pend = 0; drive();
    step();
    checks++; if (s_rd !== 2'b00) begin errors++; $display("FAIL reset_mid_rd: got %b expected 00", s_rd); end
    step();
    checks++; if (s_req !== 3'd0 || bus.cc_ph_o !== '0) begin errors++; $display("FAIL reset_mid_clear: got req %0d cc_ph %0d expected 0 0", s_req, bus.cc_ph_o); end
    rst = 1'b0;
    step(); step();
    checks++; if (s_rd !== 2'b00 || s_req !== 3'd0) begin errors++; $display("FAIL reset_mid_fsm: got rd %b req %0d expected 00 0", s_rd, s_req); end
  endtask

  task automatic test_single();
    logic [2:0] exp_req[5];
    exp_req = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd0};
    do_reset();
    bus.p_len_i = 10'd16; p_pend = 1; drive();
    run_trace(5);
    checks++; if (tr_gnt[0] !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b expected 001", tr_gnt[0]); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (tr_req[k] !== exp_req[k]) begin errors++; $display("FAIL single_req[%0d]: got %0d expected %0d", k, tr_req[k], exp_req[k]); end
    end
    checks++; if (tr_tlp[1] !== P_HDR) begin errors++; $display("FAIL single_hdr: got %0h expected %0h", tr_tlp[1], P_HDR); end
    checks++; if (tr_tlp[2] !== pdat(0) || tr_tlp[3] !== pdat(1)) begin errors++; $display("FAIL single_data: got %0h %0h expected %0h %0h", tr_tlp[2], tr_tlp[3], pdat(0), pdat(1)); end
    checks++; if (tr_tlp[4] !== pdat(1)) begin errors++; $display("FAIL single_hold: got %0h expected %0h", tr_tlp[4], pdat(1)); end
    checks++; if (bus.cc_ph_o !== 12'd1 || bus.cc_pd_o !== 12'd4) begin errors++; $display("FAIL single_cc: got ph %0d pd %0d expected 1 4", bus.cc_ph_o, bus.cc_pd_o); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rr[17];
    exp_rr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6,
               3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd0};
    do_reset();
    set_lim(1000);
    bus.p_len_i = 10'd8; bus.cpl_len_i = 10'd8;
    p_pend = 3; np_pend = 3; cpl_pend = 3; drive();
    run_trace(17);
    for (int k = 0; k < 17; k++) begin
      checks++; if (tr_req[k] !== exp_rr[k]) begin errors++; $display("FAIL rr_req[%0d]: got %0d expected %0d", k, tr_req[k], exp_rr[k]); end
    end
    checks++; if (tr_tlp[5] !== cdat(0) || tr_tlp[4] !== CPL_HDR || tr_tlp[3] !== NP_HDR) begin
      errors++; $display("FAIL rr_tlp: got %0h %0h %0h expected %0h %0h %0h", tr_tlp[3], tr_tlp[4], tr_tlp[5], NP_HDR, CPL_HDR, cdat(0)); end
    checks++; if ({bus.cc_ph_o, bus.cc_pd_o, bus.cc_nh_o, bus.cc_ch_o, bus.cc_cd_o} !== {12'd3, 12'd6, 12'd3, 12'd3, 12'd6}) begin
      errors++; $display("FAIL rr_cc: got %0d %0d %0d %0d %0d expected 3 6 3 3 6", bus.cc_ph_o, bus.cc_pd_o, bus.cc_nh_o, bus.cc_ch_o, bus.cc_cd_o); end
  endtask

  task automatic test_np_credit();
    int g;
    do_reset();
    bus.cl_nh_i = 12'd2; np_pend = 5; drive();
    run_trace(6);
    g = 0;
    for (int k = 0; k < 6; k++) if (tr_gnt[k][1]) g++;
    checks++; if (g != 2 || bus.cc_nh_o !== 12'd2) begin errors++; $display("FAIL np_limit: got grants %0d cc_nh %0d expected 2 2", g, bus.cc_nh_o); end
    checks++; if (tr_gnt[0] !== 3'b010 || tr_gnt[1] !== 3'b010 || tr_req[1] !== 3'd3 || tr_req[2] !== 3'd3) begin
      errors++; $display("FAIL np_b2b: got gnt %b %b req %0d %0d expected 010 010 3 3", tr_gnt[0], tr_gnt[1], tr_req[1], tr_req[2]); end
    checks++; if (tr_tlp[2] !== NP_HDR) begin errors++; $display("FAIL np_hdr: got %0h expected %0h", tr_tlp[2], NP_HDR); end
    bus.cl_nh_i = 12'd3;
    step();
    checks++; if (s_gnt !== 3'b010 || bus.cc_nh_o !== 12'd3) begin errors++; $display("FAIL np_release: got gnt %b cc_nh %0d expected 010 3", s_gnt, bus.cc_nh_o); end
  endtask

  task automatic send_p(input logic [9:0] len, input int dcr);
    int n;
    bus.cl_pd_i = CD'(exp_pd + 1024); bus.p_len_i = len; p_pend = 1; drive();
    n = 0;
    while (p_pend != 0 && n < 20) begin step(); n++; end
    step();
    while (s_req != 3'd0 && n < 300) begin step(); n++; end
    exp_pd = (exp_pd + dcr) % 4096;
    checks++; if (n >= 300 || p_pend != 0) begin errors++; $display("FAIL wrap_send: got pending %0d steps %0d expected 0 <300", p_pend, n); end
  endtask

  task automatic test_wrap();
    int g;
    do_reset();
    exp_pd = 0;
    for (int k = 0; k < 15; k++) send_p(10'd0, 256);
    send_p(10'd1016, 254);
    checks++; if (bus.cc_pd_o !== 12'd4094 || bus.cc_ph_o !== 12'd16) begin errors++; $display("FAIL wrap_preset: got pd %0d ph %0d expected 4094 16", bus.cc_pd_o, bus.cc_ph_o); end
    bus.cl_pd_i = 12'd4095; bus.p_len_i = 10'd8; p_pend = 1; drive();
    g = 0;
    for (int k = 0; k < 4; k++) begin step(); if (s_gnt[0]) g++; end
    checks++; if (g != 0) begin errors++; $display("FAIL wrap_block: got grants %0d expected 0", g); end
    bus.cl_pd_i = 12'd2;
    step();
    checks++; if (s_gnt !== 3'b001) begin errors++; $display("FAIL wrap_gnt: got %b expected 001", s_gnt); end
    checks++; if (bus.cc_pd_o !== 12'd0 || bus.cc_ph_o !== 12'd17) begin errors++; $display("FAIL wrap_cc: got pd %0d ph %0d expected 0 17", bus.cc_pd_o, bus.cc_ph_o); end
  endtask

  task automatic test_retry();
    int g;
    logic [2:0] exp_req[6];
    exp_req = '{3'd5, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0};
    do_reset();
    bus.retry_leftover_i = 8'd4; bus.cpl_len_i = 10'd32; cpl_pend = 1; drive();
    g = 0;
    for (int k = 0; k < 4; k++) begin step(); if (s_gnt != 3'b000) g++; end
    checks++; if (g != 0) begin errors++; $display("FAIL retry_block: got grants %0d expected 0", g); end
    bus.retry_leftover_i = 8'd5;
    step();
    checks++; if (s_gnt !== 3'b100) begin errors++; $display("FAIL retry_gnt: got %b expected 100", s_gnt); end
    run_trace(6);
    for (int k = 0; k < 6; k++) begin
      checks++; if (tr_req[k] !== exp_req[k]) begin errors++; $display("FAIL retry_req[%0d]: got %0d expected %0d", k, tr_req[k], exp_req[k]); end
    end
    checks++; if (tr_tlp[4] !== cdat(3) || tr_tlp[0] !== CPL_HDR) begin errors++; $display("FAIL retry_tlp: got %0h %0h expected %0h %0h", tr_tlp[0], tr_tlp[4], CPL_HDR, cdat(3)); end
    checks++; if (bus.cc_ch_o !== 12'd1 || bus.cc_cd_o !== 12'd8) begin errors++; $display("FAIL retry_cc: got ch %0d cd %0d expected 1 8", bus.cc_ch_o, bus.cc_cd_o); end
  endtask

  task automatic test_link_drop();
    int g;
    logic [2:0] exp_req[6];
    exp_req = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
    do_reset();
    bus.p_len_i = 10'd32; p_pend = 2; drive();
    step();
    checks++; if (s_gnt !== 3'b001) begin errors++; $display("FAIL link_gnt: got %b expected 001", s_gnt); end
    step();
    bus.link_active_i = 1'b0;
    run_trace(6);
    g = 0;
    for (int k = 0; k < 6; k++) begin
      if (tr_gnt[k] != 3'b000) g++;
      checks++; if (tr_req[k] !== exp_req[k]) begin errors++; $display("FAIL link_req[%0d]: got %0d expected %0d", k, tr_req[k], exp_req[k]); end
    end
    checks++; if (g != 0 || tr_tlp[3] !== pdat(3)) begin errors++; $display("FAIL link_drain: got grants %0d last %0h expected 0 %0h", g, tr_tlp[3], pdat(3)); end
    bus.link_active_i = 1'b1;
    step();
    checks++; if (s_gnt !== 3'b001) begin errors++; $display("FAIL link_up: got %b expected 001", s_gnt); end
  endtask

  task automatic test_prio();
    int ord[4];
    int exp_ord[4];
    int n;
`ifdef PCIE_TX_CPL_PRIO_EN
    exp_ord = '{2, 2, 0, 0};
`else
    exp_ord = '{0, 2, 0, 2};
`endif
    do_reset();
    bus.p_len_i = 10'd8; bus.cpl_len_i = 10'd8;
    p_pend = 2; cpl_pend = 2; drive();
    n = 0;
    ord = '{-1, -1, -1, -1};
    for (int k = 0; k < 20 && n < 4; k++) begin
      step();
      if (s_gnt[0]) begin ord[n] = 0; n++; end
      else if (s_gnt[2]) begin ord[n] = 2; n++; end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ord[k] != exp_ord[k]) begin errors++; $display("FAIL prio_order[%0d]: got %0d expected %0d", k, ord[k], exp_ord[k]); end
    end
  endtask

  initial begin
    bus.p_hdr_i = P_HDR; bus.np_hdr_i = NP_HDR; bus.cpl_hdr_i = CPL_HDR;
    bus.p_len_i = 10'd16; bus.cpl_len_i = 10'd16;
    test_reset();
    test_single();
    test_round_robin();
    test_np_credit();
    test_wrap();
    test_retry();
    test_link_drop();
    test_prio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
